// File: rtl/if_pc_stage.sv
// ----------------------------------------------------------------------------
// if_pc_stage
//
// Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program
// counter and the IF/ID pipeline register. Each cycle it picks the next fetch
// address from one of these sources:
//   - sequential fetch (pc+4)
//   - a redirect resolved in ID (branch, jr/jalr, j/jal)
//   - the interrupt vector
// Any redirect or interrupt turns the wrong-path fetch into a bubble in IF/ID.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   instr_in            instruction-memory read data for address pc
//   stall               load-use hazard: freeze pc, IF/ID and epc
//   branch_taken        ID conditional branch resolved taken
//   id_imm16            branch immediate of the instruction in ID
//   jump, id_index26    j/jal request and its instr_index field
//   jr, jr_addr         jr/jalr request and the forwarded rs value
//   irq                 level-sensitive interrupt request
//   pc                  current fetch address
//   if_id_instr         instruction handed to ID
//   if_id_pc_plus4      pc+4 of that instruction
//   if_id_valid         1 = real instruction, 0 = bubble
//   epc                 return address captured on interrupt entry
//   irq_ack             one-cycle pulse after an interrupt is taken
// ----------------------------------------------------------------------------
module if_pc_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] IRQ_VEC  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] id_imm16,
    input  logic        jump,
    input  logic [25:0] id_index26,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        irq,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] epc,
    output logic        irq_ack
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] epc_q, epc_d;
    logic        irq_ack_q, irq_ack_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] redir_tgt;
    logic        redir;

    // Target generation and next-state selection. A bubble in ID cannot
    // request a redirect, so the request bits are gated by if_id_valid.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        br_tgt   = if_id_pc_plus4_q + {{14{id_imm16[15]}}, id_imm16, 2'b00};
        j_tgt    = {if_id_pc_plus4_q[31:28], id_index26, 2'b00};
        redir    = if_id_valid_q & (branch_taken | jump | jr);

        // Several requests at once is illegal; the fixed order keeps it
        // deterministic.
        if (branch_taken) begin
            redir_tgt = br_tgt;
        end else if (jr) begin
            redir_tgt = jr_addr;
        end else begin
            redir_tgt = j_tgt;
        end

        pc_d             = pc_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_valid_d    = if_id_valid_q;
        epc_d            = epc_q;
        irq_ack_d        = 1'b0;

        // While stalled the branch operands may still be in flight, so both
        // redirects and interrupt entry wait until the stall clears.
        if (!stall) begin
            if (irq) begin
                // The return point is where execution would have continued:
                // the redirect target, or else the fetch being thrown away.
                epc_d            = redir ? redir_tgt : pc_q;
                pc_d             = IRQ_VEC;
                if_id_instr_d    = 32'd0;
                if_id_pc_plus4_d = 32'd0;
                if_id_valid_d    = 1'b0;
                irq_ack_d        = 1'b1;
            end else if (redir) begin
                pc_d             = redir_tgt;
                if_id_instr_d    = 32'd0;
                if_id_pc_plus4_d = 32'd0;
                if_id_valid_d    = 1'b0;
            end else begin
                pc_d             = pc_plus4;
                if_id_instr_d    = instr_in;
                if_id_pc_plus4_d = pc_plus4;
                if_id_valid_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q             <= RESET_PC;
            if_id_instr_q    <= 32'd0;
            if_id_pc_plus4_q <= 32'd0;
            if_id_valid_q    <= 1'b0;
            epc_q            <= 32'd0;
            irq_ack_q        <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_valid_q    <= if_id_valid_d;
            epc_q            <= epc_d;
            irq_ack_q        <= irq_ack_d;
        end
    end

    assign pc             = pc_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_valid    = if_id_valid_q;
    assign epc            = epc_q;
    assign irq_ack        = irq_ack_q;

endmodule

// File: tb/tb_if_pc_stage.sv
// ----------------------------------------------------------------------------
// tb_if_pc_stage
//
// Bench for if_pc_stage. It runs directed scenarios and then randomized
// traffic. A cycle-level reference model, written from the fetch rules,
// predicts every output after each clock edge.
// ----------------------------------------------------------------------------
module tb_if_pc_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] IRQ_VEC  = 32'h0000_0080;

    logic        clk;
    logic        reset;
    logic [31:0] instr_in;
    logic        stall;
    logic        branch_taken;
    logic [15:0] id_imm16;
    logic        jump;
    logic [25:0] id_index26;
    logic        jr;
    logic [31:0] jr_addr;
    logic        irq;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] epc;
    logic        irq_ack;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pp4;
    logic        m_valid;
    logic [31:0] m_epc;
    logic        m_ack;

    if_pc_stage #(
        .RESET_PC(RESET_PC),
        .IRQ_VEC (IRQ_VEC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_in      (instr_in),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .id_imm16      (id_imm16),
        .jump          (jump),
        .id_index26    (id_index26),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .irq           (irq),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid),
        .epc           (epc),
        .irq_ack       (irq_ack)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the reference model by one clock, working directly from the
    // fetch rules: reset > stall > interrupt > redirect > sequential.
    task automatic modelStep(input logic r, input logic s, input logic br, input logic jmp,
                             input logic jrr, input logic irqv, input logic [15:0] imm,
                             input logic [25:0] idx, input logic [31:0] jra,
                             input logic [31:0] ins);
        int          offset;
        logic [31:0] tgt;
        logic        wants;
        if (r) begin
            m_pc = RESET_PC; m_instr = 0; m_pp4 = 0; m_valid = 0; m_epc = 0; m_ack = 0;
        end else if (s) begin
            m_ack = 0;
        end else begin
            wants  = m_valid && (br || jmp || jrr);
            offset = int'($signed(imm)) * 4;
            if (br)       tgt = m_pp4 + 32'(offset);
            else if (jrr) tgt = jra;
            else          tgt = (m_pp4 & 32'hF000_0000) | (32'(idx) * 32'd4);
            if (irqv) begin
                m_epc = wants ? tgt : m_pc;
                m_pc = IRQ_VEC; m_instr = 0; m_pp4 = 0; m_valid = 0; m_ack = 1;
            end else if (wants) begin
                m_pc = tgt; m_instr = 0; m_pp4 = 0; m_valid = 0; m_ack = 0;
            end else begin
                m_instr = ins; m_pp4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
                m_valid = 1; m_ack = 0;
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge, clock it in, then compare
    // every output with the model just after the rising edge.
    task automatic applyStimulus(input logic r, input logic s, input logic br, input logic jmp,
                                 input logic jrr, input logic irqv, input logic [15:0] imm,
                                 input logic [25:0] idx, input logic [31:0] jra,
                                 input logic [31:0] ins);
        @(negedge clk);
        reset = r; stall = s; branch_taken = br; jump = jmp; jr = jrr; irq = irqv;
        id_imm16 = imm; id_index26 = idx; jr_addr = jra; instr_in = ins;
        modelStep(r, s, br, jmp, jrr, irqv, imm, idx, jra, ins);
        @(posedge clk);
        #1;
        checkOutput("pc",        pc,                    m_pc);
        checkOutput("instr",     if_id_instr,           m_instr);
        checkOutput("pc_plus4",  if_id_pc_plus4,        m_pp4);
        checkOutput("valid",     32'(if_id_valid),      32'(m_valid));
        checkOutput("epc",       epc,                   m_epc);
        checkOutput("irq_ack",   32'(irq_ack),          32'(m_ack));
    endtask

    // Shorthands for common cycle types; instr_in follows the model's fetch pc
    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic freeCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, m_pc);
    endtask

    initial begin
        reset = 1; stall = 0; branch_taken = 0; jump = 0; jr = 0; irq = 0;
        id_imm16 = 0; id_index26 = 0; jr_addr = 0; instr_in = 0;

        // Reset state and sequential fetch
        doReset();
        checkOutput("rst_pc",    pc,                32'h0);
        checkOutput("rst_valid", 32'(if_id_valid),  32'h0);
        freeCycle();
        checkOutput("seq_pc4",   pc,                32'h4);
        checkOutput("seq_pp4",   if_id_pc_plus4,    32'h4);
        checkOutput("seq_valid", 32'(if_id_valid),  32'h1);
        freeCycle();
        freeCycle();
        checkOutput("seq_pcC",   pc,                32'hC);
        checkOutput("seq_instr", if_id_instr,       32'h8);

        // Backward branch from pc_plus4 = 0x14
        freeCycle();
        freeCycle();
        checkOutput("pre_br_pp4", if_id_pc_plus4,   32'h14);
        applyStimulus(0, 0, 1, 0, 0, 0, 16'hFFFE, 0, 0, m_pc);
        checkOutput("br_pc",     pc,                32'hC);
        checkOutput("br_bubble", 32'(if_id_valid),  32'h0);
        freeCycle();
        checkOutput("br_resume", if_id_pc_plus4,    32'h10);

        // jr to 0x9000_0000, fetch once, then j keeps the upper nibble
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 32'h9000_0000, m_pc);
        checkOutput("jr_pc",     pc,                32'h9000_0000);
        freeCycle();
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 26'h0000010, 0, m_pc);
        checkOutput("j_pc",      pc,                32'h9000_0040);
        freeCycle();
        // branch and jr together: branch target wins
        applyStimulus(0, 0, 1, 0, 1, 0, 16'h0001, 0, 32'h1234, m_pc);
        checkOutput("prio_pc",   pc,                32'h9000_0048);

        // Stall with a pending branch, then release
        freeCycle();
        applyStimulus(0, 1, 1, 0, 0, 0, 16'h0010, 0, 0, m_pc);
        applyStimulus(0, 1, 1, 0, 0, 0, 16'h0010, 0, 0, m_pc);
        checkOutput("stall_pc",  pc,                32'h9000_004C);
        applyStimulus(0, 0, 1, 0, 0, 0, 16'h0010, 0, 0, m_pc);
        checkOutput("stall_br",  pc,                32'h9000_008C);

        // Interrupt at pc = 0x20 with no redirect
        doReset();
        for (int i = 0; i < 8; i++) freeCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, m_pc);
        checkOutput("irq_pc",    pc,                IRQ_VEC);
        checkOutput("irq_epc",   epc,               32'h20);
        checkOutput("irq_ack1",  32'(irq_ack),      32'h1);
        freeCycle();
        checkOutput("irq_ack0",  32'(irq_ack),      32'h0);
        // Interrupt together with a taken branch to 0x40 (0x84 - 0x44)
        applyStimulus(0, 0, 1, 0, 0, 1, 16'hFFEF, 0, 0, m_pc);
        checkOutput("irq_br_epc", epc,              32'h40);

        // Reset wins over stall and over irq
        freeCycle();
        applyStimulus(1, 1, 1, 0, 0, 0, 16'h0004, 0, 0, m_pc);
        checkOutput("rst_stall", pc,                32'h0);
        freeCycle();
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, m_pc);
        checkOutput("rst_irq_ack", 32'(irq_ack),    32'h0);
        checkOutput("rst_irq_epc", epc,             32'h0);

        // PC wrap-around at the top of the address space
        freeCycle();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, m_pc);
        freeCycle();
        checkOutput("wrap_pc",   pc,                32'h0);
        checkOutput("wrap_pp4",  if_id_pc_plus4,    32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        r, s, br, jmp, jrr, iq;
            logic [31:0] jra;
            r   = ($urandom_range(0, 40) == 0);
            s   = ($urandom_range(0, 5) == 0);
            br  = ($urandom_range(0, 5) == 0);
            jmp = ($urandom_range(0, 6) == 0);
            jrr = ($urandom_range(0, 6) == 0);
            iq  = ($urandom_range(0, 12) == 0);
            jra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
            applyStimulus(r, s, br, jmp, jrr, iq, 16'($urandom), 26'($urandom), jra, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_pc_stage.md
Name: if_pc_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register and the IF/ID pipeline register.
- Consumes the ID-stage branch decision (branch-taken bit), jump/jr requests, the load-use stall and an external interrupt.
- Selects the next PC, computes branch/jump targets, and squashes the wrong-path instruction in IF/ID on any redirect.
- Directly upstream of ID/branch evaluation, which reads if_id_instr / if_id_pc_plus4.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IRQ_VEC, 32'h0000_0080, PC loaded when an interrupt is taken.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_in  input  32  instruction-memory read data for address pc (combinational read, same cycle).
- stall  input  1  load-use hazard from hazard unit; freeze PC and IF/ID.
- branch_taken  input  1  ID-stage conditional branch resolved taken.
- id_imm16  input  16  immediate field of the instruction in ID.
- jump  input  1  ID holds j/jal.
- id_index26  input  26  instr_index field of the instruction in ID.
- jr  input  1  ID holds jr/jalr.
- jr_addr  input  32  forwarded rs value for jr/jalr.
- irq  input  1  level interrupt request.
- pc  output  32  current fetch address to instruction memory.
- if_id_instr  output  32  instruction latched for ID.
- if_id_pc_plus4  output  32  PC+4 of the latched instruction.
- if_id_valid  output  1  1 = real instruction, 0 = bubble.
- epc  output  32  return address captured on interrupt entry.
- irq_ack  output  1  one-cycle pulse on the cycle after an interrupt is taken.

Behaviour:
- Reset (sync): pc=RESET_PC, if_id_instr=0, if_id_pc_plus4=0, if_id_valid=0, epc=0, irq_ack=0. Reset overrides every other input in the same cycle.
- Targets, combinational, 32-bit wrap-around arithmetic, no overflow detection:
  - br_tgt = if_id_pc_plus4 + (sign_extend(id_imm16) << 2)
  - j_tgt = {if_id_pc_plus4[31:28], id_index26, 2'b00}
  - jr_tgt = jr_addr (bits[1:0] passed through unmodified)
- Redirect request: redir = if_id_valid & (branch_taken | jump | jr). Request inputs are ignored while if_id_valid=0.
- Redirect target priority: branch_taken > jr > jump. More than one asserted is illegal but deterministic by this order.
- Per-cycle priority (highest first):
  1. reset.
  2. stall=1: pc, IF/ID, epc held; redir ignored (branch operands not yet valid). irq not taken this cycle.
  3. irq=1: pc<=IRQ_VEC; IF/ID<=bubble (instr 0, valid 0, pc_plus4 0); epc<= redirect target if redir else pc (the discarded fetch); irq_ack=1 next cycle.
  4. redir=1: pc<=selected target; IF/ID<=bubble. Exactly one squash slot, no branch delay slot.
  5. otherwise: pc<=pc+4; if_id_instr<=instr_in; if_id_pc_plus4<=pc+4; if_id_valid<=1.
- irq_ack is registered: 1 for exactly one cycle after each taken interrupt.
  - irq held high re-enters every non-stalled cycle; masking is upstream's job.
- pc+4 wraps 32'hFFFF_FFFC -> 0.
- Latency: redirect decided in ID at cycle N, target fetched at cycle N+1; one bubble per taken redirect.

Test Plan:
- Reset then 4 free cycles, instr_in=pc -> pc 0,4,8,C; if_id_pc_plus4 4,8,C; valid=1 from 2nd cycle.
- ID at pc_plus4=0x14, branch_taken=1, imm16=0xFFFE -> next pc=0x0C, if_id_valid=0 one cycle, then resumes at 0x0C.
- jump with if_id_pc_plus4=0x9000_0004, index26=0x0000010 -> pc=0x9000_0040; jr=1, jr_addr=0x1234 simultaneously with branch_taken=1 -> branch target wins.
- stall=1 for 2 cycles with branch_taken=1 -> pc/IF/ID unchanged both cycles; branch redirects on first cycle stall=0.
- irq=1 at pc=0x20, no redir -> pc=IRQ_VEC, epc=0x20, irq_ack pulse; irq with taken branch to 0x40 -> epc=0x40.
- reset asserted mid-stall and mid-irq -> all outputs at reset values next edge; pc=0xFFFF_FFFC free-runs -> wraps to 0.
